mash_stage: RTL and testbench
=============================

MASH_STAGE -- requirements
Module: mash_stage

Interface
REQ-001 SHALL have parameter IN_W, default 32, target/residue width.
REQ-002 SHALL have parameter Q_W, default 16, quantiser output width; legal 1..IN_W-1.
REQ-003 SHALL have parameter DIFF_ORDER, default 1, differencing order; legal 1..3.
REQ-004 SHALL have parameter ALIGN_DLY, default 2, output alignment delay in samples; legal 0..7.
REQ-005 SHALL define CW = Q_W+DIFF_ORDER-1, the output magnitude width.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-008 SHALL have port ce  input  1  sample strobe; pipeline advances only when 1.
REQ-009 SHALL have port A  input  IN_W  unsigned target for this stage.
REQ-010 SHALL have port C  output  CW  magnitude of the differenced quantiser output.
REQ-011 SHALL have port Csgn  output  1  sign of C, 1 = negative.
REQ-012 SHALL have port nxttgt  output  IN_W  residue for the next stage.
REQ-013 SHALL have port out_valid  output  1  high once the pipeline is full.

Function
REQ-014 SHALL, on ce=1, register quant = A[IN_W-1 -: Q_W] and nxttgt = A with its top Q_W bits cleared (IN_W-Q_W LSBs, zero-extended).
REQ-015 SHALL apply (1 - z^-1)^DIFF_ORDER to quant as a cascade of DIFF_ORDER registered first differences, each computed in two's complement wide enough to be exact.
REQ-016 SHALL convert the final difference to sign-magnitude: Csgn=1 only for strictly negative values; zero gives Csgn=0, C=0.
REQ-017 SHALL delay {C,Csgn} by ALIGN_DLY further ce-strobes; ALIGN_DLY=0 drives C directly from the last difference register.
REQ-018 SHALL have latency L = 1+DIFF_ORDER+ALIGN_DLY ce-strobes from A to C and 1 ce-strobe from A to nxttgt.
REQ-019 SHALL hold every register, including nxttgt, C, Csgn and the fill counter, while ce=0.
REQ-020 SHALL count ce-strobes after reset in a saturating fill counter and assert out_valid from the cycle after the L-th strobe; out_valid then stays high until reset.
REQ-021 SHALL treat all difference history as zero after reset, so the first valid C equals the first quant with Csgn=0 when DIFF_ORDER=1.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, clear quant, nxttgt, all difference, delay and history registers, C, Csgn, out_valid and the fill counter to 0; rst overrides ce.
REQ-023 SHALL apply reset identically mid-stream, discarding in-flight samples; refill then takes L strobes again.

Configuration
REQ-024 SHALL, with MASH_STAGE_DITHER_EN defined, add a 1-bit dither d = lfsr[0] to A modulo 2^IN_W before REQ-014, computing quant and nxttgt from the sum.
REQ-025 SHALL, with dither enabled, use a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, reset to 16'hACE1 and advanced on ce only.
REQ-026 SHALL, without MASH_STAGE_DITHER_EN, contain no LFSR and behave exactly per REQ-014.

Structure
REQ-027 SHALL take default widths, the CW computation function, the LFSR seed and tap mask from shared package mash_pkg.
REQ-028 SHALL implement one first-difference stage as sub-module mash_ddiff (registered signed a - a_prev with ce/rst), instantiated DIFF_ORDER times in a generate loop.

Verification
REQ-029 SHALL test defaults with A held at 32'h0001_8000 -> nxttgt=32'h0000_8000 after 1 strobe; C=1, Csgn=0 at strobe 4 (out_valid rises); C=0 thereafter.
REQ-030 SHALL test DIFF_ORDER=1 with A=32'h0005_0000 then 32'h0003_0000 -> C=5,Csgn=0 followed by C=2,Csgn=1, ALIGN_DLY strobes after the difference stage.
REQ-031 SHALL test DIFF_ORDER=2, ALIGN_DLY=0 with quant ramp 0,1,2,3,3 -> C sequence 0,1,0,0,1 with Csgn 0,0,0,0,1 at latency 3.
REQ-032 SHALL test ce toggling 1,0,0,1 with changing A -> outputs frozen during ce=0; latency counted in strobes, not cycles.
REQ-033 SHALL test rst pulsed mid-stream for one cycle with ce=1 -> all outputs 0 on the next cycle; out_valid low until L new strobes.
REQ-034 SHALL test with MASH_STAGE_DITHER_EN and A=32'h0000_FFFF -> quant toggles between 0 and 1 following lfsr[0] from seed 16'hACE1; nxttgt=(A+d) mod 2^16.

Source files
------------

// File: rtl/mash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mash_pkg
// Purpose  : Shared widths, output-width helper and dither LFSR constants
//            for the MASH stage.
// Revision : 1.0
// ============================================================================
package mash_pkg;

   localparam int MASH_IN_W       = 32;
   localparam int MASH_Q_W        = 16;
   localparam int MASH_DIFF_ORDER = 1;
   localparam int MASH_ALIGN_DLY  = 2;

   // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
   localparam logic [15:0] MASH_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] MASH_LFSR_TAPS = 16'hB400;

   function automatic int calc_cw(input int q_w, input int order);
      return q_w + order - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mash_ddiff.sv
`default_nettype none
// ============================================================================
// Module   : mash_ddiff
// Purpose  : One registered first difference (a - a_prev), advanced on ce.
// Revision : 1.0
// ============================================================================
module mash_ddiff
   import mash_pkg::*;
#(
   parameter int W = MASH_Q_W + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic signed [W-1:0] i_a,
   output logic signed [W-1:0] o_d
);

   logic signed [W-1:0] r_prev;
   logic signed [W-1:0] r_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= '0;
         r_d    <= '0;
      end else if (ce) begin
         r_prev <= i_a;
         r_d    <= i_a - r_prev;
      end
   end

   assign o_d = r_d;

endmodule
`default_nettype wire

// File: rtl/mash_stage.sv
`default_nettype none
// ============================================================================
// Module   : mash_stage
// Purpose  : MASH quantiser stage: split target into quantised MSBs and
//            residue, difference the MSBs DIFF_ORDER times, emit sign-magnitude.
//            Optional dither enabled by defining MASH_STAGE_DITHER_EN.
// Revision : 1.0
// ============================================================================
module mash_stage
   import mash_pkg::*;
#(
   parameter int  IN_W       = MASH_IN_W,
   parameter int  Q_W        = MASH_Q_W,
   parameter int  DIFF_ORDER = MASH_DIFF_ORDER,
   parameter int  ALIGN_DLY  = MASH_ALIGN_DLY,
   localparam int CW         = calc_cw(Q_W, DIFF_ORDER)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce,
   input  logic [IN_W-1:0] A,
   output logic [CW-1:0]   C,
   output logic            Csgn,
   output logic [IN_W-1:0] nxttgt,
   output logic            out_valid
);

   localparam int          DW     = Q_W + DIFF_ORDER;
   localparam int          LAT    = 1 + DIFF_ORDER + ALIGN_DLY;
   localparam logic [3:0]  c_FILL = 4'(LAT);

   logic [IN_W-1:0] w_a;

`ifdef MASH_STAGE_DITHER_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= MASH_LFSR_SEED;
      end else if (ce) begin
         r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? MASH_LFSR_TAPS : 16'h0000);
      end
   end

   assign w_a = A + IN_W'(r_lfsr[0]);
`else
   assign w_a = A;
`endif

   logic [Q_W-1:0]  r_quant;
   logic [IN_W-1:0] r_nxttgt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_quant  <= '0;
         r_nxttgt <= '0;
      end else if (ce) begin
         r_quant  <= w_a[IN_W-1 -: Q_W];
         r_nxttgt <= {{Q_W{1'b0}}, w_a[IN_W-Q_W-1:0]};
      end
   end

   assign nxttgt = r_nxttgt;

   // All stages share the final width; intermediate differences never exceed it.
   logic signed [DW-1:0] w_stage [0:DIFF_ORDER];
   assign w_stage[0] = signed'({{DIFF_ORDER{1'b0}}, r_quant});

   generate
      for (genvar gi = 0; gi < DIFF_ORDER; gi++) begin : g_diff
         mash_ddiff #(.W(DW)) u_ddiff (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .i_a (w_stage[gi]),
            .o_d (w_stage[gi+1])
         );
      end
   endgenerate

   logic          w_neg;
   logic [CW-1:0] w_mag;

   assign w_neg = w_stage[DIFF_ORDER][DW-1];
   assign w_mag = w_neg ? CW'(-w_stage[DIFF_ORDER]) : CW'(w_stage[DIFF_ORDER]);

   generate
      if (ALIGN_DLY == 0) begin : g_noalign
         assign C    = w_mag;
         assign Csgn = w_neg;
      end else begin : g_align
         logic [CW:0] r_dly [0:ALIGN_DLY-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < ALIGN_DLY; i++) r_dly[i] <= '0;
            end else if (ce) begin
               r_dly[0] <= {w_mag, w_neg};
               for (int i = 1; i < ALIGN_DLY; i++) r_dly[i] <= r_dly[i-1];
            end
         end

         assign {C, Csgn} = r_dly[ALIGN_DLY-1];
      end
   endgenerate

   logic [3:0] r_fill;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill <= '0;
      end else if (ce && (r_fill != c_FILL)) begin
         r_fill <= r_fill + 4'd1;
      end
   end

   assign out_valid = (r_fill == c_FILL);

endmodule
`default_nettype wire

// File: tb/tb_mash_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mash_stage
// Purpose  : Scoreboard bench for two mash_stage configurations sharing one
//            stimulus stream (order 1 / align 2, and order 2 / align 0).
// Revision : 1.0
// ============================================================================
module tb_mash_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce  = 1'b0;
   logic [31:0] A   = '0;

   logic [15:0] d1_c;  logic d1_s;  logic [31:0] d1_n;  logic d1_v;
   logic [16:0] d2_c;  logic d2_s;  logic [31:0] d2_n;  logic d2_v;

   always #5 clk = ~clk;

   mash_stage #(.IN_W(32), .Q_W(16), .DIFF_ORDER(1), .ALIGN_DLY(2)) u_dut1 (
      .clk(clk), .rst(rst), .ce(ce), .A(A),
      .C(d1_c), .Csgn(d1_s), .nxttgt(d1_n), .out_valid(d1_v));

   mash_stage #(.IN_W(32), .Q_W(16), .DIFF_ORDER(2), .ALIGN_DLY(0)) u_dut2 (
      .clk(clk), .rst(rst), .ce(ce), .A(A),
      .C(d2_c), .Csgn(d2_s), .nxttgt(d2_n), .out_valid(d2_v));

   typedef struct {
      logic [15:0] c1; logic s1; logic v1;
      logic [16:0] c2; logic s2; logic v2;
      logic [31:0] nxt;
   } exp_t;

   exp_t        sb[$];
   exp_t        last_exp;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          qhist[$];
   logic [31:0] m_nxt;
   logic [15:0] m_lfsr;

   // D-th backward difference of the quant history, zero before reset, for
   // the sample that emerges L strobes after it entered.
   function automatic int dval(input int D, input int L);
      int m, n, v, coef, sgn;
      m = qhist.size(); n = m - L + 1; v = 0; coef = 1; sgn = 1;
      for (int k = 0; k <= D; k++) begin
         if (n - k >= 1) v += sgn * coef * qhist[n-k-1];
         coef = coef * (D - k) / (k + 1);
         sgn  = -sgn;
      end
      return v;
   endfunction

   task automatic step(input logic r, input logic e, input logic [31:0] a);
      exp_t        ex;
      logic [31:0] ae;
      int          v1, v2;
      @(negedge clk);
      rst = r; ce = e; A = a;
      if (r) begin
         qhist.delete();
         m_nxt  = '0;
         m_lfsr = 16'hACE1;
         ex = '{c1: '0, s1: 1'b0, v1: 1'b0, c2: '0, s2: 1'b0, v2: 1'b0, nxt: '0};
      end else if (e) begin
         ae = a;
`ifdef MASH_STAGE_DITHER_EN
         ae     = a + {31'b0, m_lfsr[0]};
         m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
         qhist.push_back(int'(ae[31:16]));
         m_nxt = {16'h0000, ae[15:0]};
         v1 = dval(1, 4);
         v2 = dval(2, 3);
         ex.c1  = 16'((v1 < 0) ? -v1 : v1);
         ex.s1  = (v1 < 0);
         ex.v1  = (qhist.size() >= 4);
         ex.c2  = 17'((v2 < 0) ? -v2 : v2);
         ex.s2  = (v2 < 0);
         ex.v2  = (qhist.size() >= 3);
         ex.nxt = m_nxt;
      end else begin
         ex = last_exp;
      end
      last_exp = ex;
      sb.push_back(ex);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("o1_C",      64'(d1_c), 64'(e.c1));
            check("o1_Csgn",   64'(d1_s), 64'(e.s1));
            check("o1_valid",  64'(d1_v), 64'(e.v1));
            check("o1_nxttgt", 64'(d1_n), 64'(e.nxt));
            check("o2_C",      64'(d2_c), 64'(e.c2));
            check("o2_Csgn",   64'(d2_s), 64'(e.s2));
            check("o2_valid",  64'(d2_v), 64'(e.v2));
            check("o2_nxttgt", 64'(d2_n), 64'(e.nxt));
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int ramp[5] = '{0, 1, 2, 3, 3};
      step(1'b1, 1'b1, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 32'h0);

      repeat (7) step(1'b0, 1'b1, 32'h0001_8000);

      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0005_0000);
      repeat (6) step(1'b0, 1'b1, 32'h0003_0000);

      step(1'b1, 1'b0, 32'h0);
      foreach (ramp[i]) step(1'b0, 1'b1, 32'(ramp[i]) << 16);
      repeat (4) step(1'b0, 1'b1, 32'h0003_0000);

      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, $urandom);
         step(1'b0, 1'b0, $urandom);
         step(1'b0, 1'b0, $urandom);
         step(1'b0, 1'b1, $urandom);
      end

      step(1'b1, 1'b1, $urandom);
      repeat (6) step(1'b0, 1'b1, $urandom);

`ifdef MASH_STAGE_DITHER_EN
      step(1'b1, 1'b0, 32'h0);
      repeat (12) step(1'b0, 1'b1, 32'h0000_FFFF);
`endif

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[31:18] = '0;
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), a);
      end

      repeat (3) @(posedge clk);
      #2;
      check("drain", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
